// File: rtl/bcd_seg_display.sv
// rtl/bcd_seg_display.sv - iterative binary-to-BCD converter driving active-low 7-segment digits
module bcd_seg_display #(
  parameter int IN_W     = 8,
  parameter int DIGITS   = 3,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   segs,
  output logic                  overflow
);

  // Number of decimal digits needed to hold v.
  function automatic int dec_digits(input int v);
    int n;
    int x;
    n = 1;
    x = v;
    while (x >= 10) begin
      x = x / 10;
      n = n + 1;
    end
    return n;
  endfunction

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Scratch holds the full decimal result of the largest input, even if wider than DIGITS.
  localparam int          NS   = dec_digits((1 << IN_W) - 1);
  localparam int          SW   = 4 * NS;
  localparam int          CW   = $clog2(IN_W + 1);
  localparam logic [31:0] MAXV = 32'(pow10(DIGITS) - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_nxt;
  logic [IN_W-1:0]     value_q;
  logic [IN_W-1:0]     shift_q, shift_nxt;
  logic [SW-1:0]       scratch_q, scratch_adj, scratch_nxt;
  logic [CW-1:0]       count_q;
  logic                last_shift;
  logic [4*(NS+DIGITS)-1:0] scratch_pad;
  logic [4*DIGITS-1:0] bcd_fin;
  logic                ovf_fin;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0011000;
      default: seg7 = 7'b0111111;
    endcase
  endfunction

  // Full display image: dashes on overflow, otherwise digits with optional leading-zero blanking.
  function automatic logic [7*DIGITS-1:0] segs_of(input logic [4*DIGITS-1:0] b, input logic ovf);
    logic [7*DIGITS-1:0] s;
    logic                hz;
    s  = '0;
    hz = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hz = hz & (b[4*k +: 4] == 4'd0);
      if (ovf)
        s[7*k +: 7] = 7'b0111111;
      else if (BLANK_LZ && (k > 0) && hz)
        s[7*k +: 7] = 7'b1111111;
      else
        s[7*k +: 7] = seg7(b[4*k +: 4]);
    end
    return s;
  endfunction

  // One shift-and-add-3 step: correct every nibble >= 5, then shift {scratch, shift} left.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < NS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    scratch_nxt = {scratch_adj[SW-2:0], shift_q[IN_W-1]};
    shift_nxt   = shift_q << 1;
    scratch_pad = {{(4*DIGITS){1'b0}}, scratch_nxt};
    bcd_fin     = scratch_pad[4*DIGITS-1:0];
    ovf_fin     = 32'(value_q) > MAXV;
    last_shift  = (count_q == CW'(IN_W - 1));
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last_shift) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers; results are captured on the final shift so they appear with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      value_q   <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      bcd       <= '0;
      segs      <= segs_of('0, 1'b0);
      overflow  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      case (state_q)
        IDLE: begin
          if (start) begin
            value_q   <= value;
            shift_q   <= value;
            scratch_q <= '0;
            count_q   <= '0;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_nxt;
          shift_q   <= shift_nxt;
          count_q   <= count_q + CW'(1);
          if (last_shift) begin
            bcd      <= bcd_fin;
            segs     <= segs_of(bcd_fin, ovf_fin);
            overflow <= ovf_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seg_display.sv
// tb/tb_bcd_seg_display.sv - scoreboard bench for bcd_seg_display over three parameter sets
module tb_bcd_seg_display;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [7:0] value;

  logic        busy_a, done_a, ovf_a;
  logic [11:0] bcd_a;
  logic [20:0] segs_a;
  logic        busy_b, done_b, ovf_b;
  logic [11:0] bcd_b;
  logic [20:0] segs_b;
  logic        busy_c, done_c, ovf_c;
  logic [7:0]  bcd_c;
  logic [13:0] segs_c;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [11:0] bcd;
    logic [20:0] segs;
    logic        ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

  always #5 clk = ~clk;

  bcd_seg_display #(.IN_W(8), .DIGITS(3), .BLANK_LZ(1'b1)) u_a (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .segs(segs_a), .overflow(ovf_a)
  );

  bcd_seg_display #(.IN_W(8), .DIGITS(3), .BLANK_LZ(1'b0)) u_b (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .segs(segs_b), .overflow(ovf_b)
  );

  bcd_seg_display #(.IN_W(8), .DIGITS(2), .BLANK_LZ(1'b1)) u_c (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .segs(segs_c), .overflow(ovf_c)
  );

  function automatic exp_t model(input int v, input int nd, input bit blank);
    exp_t e;
    int   p;
    int   d;
    bit   hz;
    e     = '0;
    e.ovf = (v > ((nd == 3) ? 999 : 99));
    p = 1;
    for (int k = 0; k < nd; k++) begin
      d = (v / p) % 10;
      e.bcd[4*k +: 4] = 4'(d);
      p = p * 10;
    end
    hz = 1'b1;
    for (int k = nd - 1; k >= 0; k--) begin
      d  = int'(e.bcd[4*k +: 4]);
      hz = hz && (d == 0);
      if (e.ovf)                    e.segs[7*k +: 7] = 7'b0111111;
      else if (blank && k > 0 && hz) e.segs[7*k +: 7] = 7'b1111111;
      else                          e.segs[7*k +: 7] = SEG_TAB[d];
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every done pulse with the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done_a) begin
      if (q_a.size() == 0) chk("a_spurious_done", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        chk("a_bcd", 32'(bcd_a), 32'(e.bcd));
        chk("a_segs", 32'(segs_a), 32'(e.segs));
        chk("a_ovf", 32'(ovf_a), 32'(e.ovf));
      end
    end
    if (done_b) begin
      if (q_b.size() == 0) chk("b_spurious_done", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        chk("b_bcd", 32'(bcd_b), 32'(e.bcd));
        chk("b_segs", 32'(segs_b), 32'(e.segs));
        chk("b_ovf", 32'(ovf_b), 32'(e.ovf));
      end
    end
    if (done_c) begin
      if (q_c.size() == 0) chk("c_spurious_done", 32'd1, 32'd0);
      else begin
        e = q_c.pop_front();
        chk("c_bcd", 32'(bcd_c), 32'(e.bcd[7:0]));
        chk("c_segs", 32'(segs_c), 32'(e.segs[13:0]));
        chk("c_ovf", 32'(ovf_c), 32'(e.ovf));
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic start_conv(input int v);
    value = 8'(v);
    start = 1'b1;
    q_a.push_back(model(v, 3, 1'b1));
    q_b.push_back(model(v, 3, 1'b0));
    q_c.push_back(model(v, 2, 1'b1));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 1;
    while (!done_a && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done_a), 32'd1);
    chk("latency", 32'(n), 32'd9);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'({busy_a, busy_b, busy_c}), 32'd0);
    chk({tag, "_done"}, 32'({done_a, done_b, done_c}), 32'd0);
    chk({tag, "_ovf"}, 32'({ovf_a, ovf_b, ovf_c}), 32'd0);
    chk({tag, "_bcd_a"}, 32'(bcd_a), 32'd0);
    chk({tag, "_bcd_b"}, 32'(bcd_b), 32'd0);
    chk({tag, "_bcd_c"}, 32'(bcd_c), 32'd0);
    chk({tag, "_segs_a"}, 32'(segs_a), 32'({7'b1111111, 7'b1111111, 7'b1000000}));
    chk({tag, "_segs_b"}, 32'(segs_b), 32'({7'b1000000, 7'b1000000, 7'b1000000}));
    chk({tag, "_segs_c"}, 32'(segs_c), 32'({7'b1111111, 7'b1000000}));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int vals[9] = '{7, 0, 100, 99, 250, 1, 9, 10, 13};
    rst   = 1'b1;
    start = 1'b0;
    value = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // 255: exact busy/done timeline
    start_conv(255);
    for (int n = 1; n <= 9; n++) begin
      chk($sformatf("busy_n%0d", n), 32'(busy_a), 32'(n < 9));
      chk($sformatf("done_n%0d", n), 32'(done_a), 32'(n == 9));
      if (n < 9) @(negedge clk);
    end
    @(negedge clk);
    chk("idle_after_done", 32'({busy_a, done_a}), 32'd0);

    // Back-to-back conversions across blanking and overflow cases
    foreach (vals[i]) begin
      start_conv(vals[i]);
      wait_done();
    end

    // Starts during SHIFT and DONE are ignored; value change after latch has no effect
    start_conv(42);
    @(negedge clk);
    @(negedge clk);
    value = 8'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ovl_busy_n4", 32'(busy_a), 32'd1);
    repeat (5) @(negedge clk);
    chk("ovl_done_n9", 32'(done_a), 32'd1);
    value = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_cycle_start_ignored", 32'(busy_a), 32'd0);
    @(negedge clk);
    chk("still_idle", 32'({busy_a, done_a}), 32'd0);

    // Reset mid-conversion aborts without a done pulse
    start_conv(128);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q_a.delete();
    q_b.delete();
    q_c.delete();
    @(negedge clk);
    rst = 1'b0;
    chk_reset("abort");
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_done", 32'({done_a, done_b, done_c, busy_a}), 32'd0);
    end

    start_conv(13);
    wait_done();
    start_conv(128);
    wait_done();

    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
